// File: rtl/npu_act_wr_arbiter.sv
// npu_act_wr_arbiter
// Round-robin merge of per-MAC activation write requests onto the single
// activation memory write port. One grant per cycle, a registered one-cycle
// ack to the winning lane, and a saturating per-layer write counter.

module npu_act_wr_arbiter #(
    parameter int NUM_REQ    = 32,
    parameter int ADDR_WIDTH = 12,
    parameter int DATA_WIDTH = 16,
    parameter int CNT_WIDTH  = 13
) (
    input  logic                           clk,
    input  logic                           resetn,
    input  logic                           layer_start_p,
    input  logic [NUM_REQ-1:0]             hw_mem_wr,
    input  logic [NUM_REQ*ADDR_WIDTH-1:0]  hw_mem_wr_addr,
    input  logic [NUM_REQ*DATA_WIDTH-1:0]  hw_mem_wr_data,
    output logic [NUM_REQ-1:0]             hw_mem_wr_ack_p,
    output logic                           act_mem_wr_en,
    output logic [ADDR_WIDTH-1:0]          act_mem_wr_addr,
    output logic [DATA_WIDTH-1:0]          act_mem_wr_data,
    output logic [CNT_WIDTH-1:0]           wr_count_o,
    output logic                           busy_o
);

    localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;
    localparam logic [PTR_W-1:0]     LAST_LANE = PTR_W'(NUM_REQ - 1);

    logic [NUM_REQ-1:0]    eligible;
    logic [PTR_W-1:0]      rr_ptr;
    logic [PTR_W-1:0]      rr_ptr_next;
    logic                  grant_vld;
    logic [PTR_W-1:0]      grant_idx;
    logic [NUM_REQ-1:0]    grant_onehot;
    logic [ADDR_WIDTH-1:0] grant_addr;
    logic [DATA_WIDTH-1:0] grant_data;

    // A lane acked this cycle may still be holding its request; mask it so
    // the same write is never granted twice.
    assign eligible = hw_mem_wr & ~hw_mem_wr_ack_p;

    // Scan lanes starting at rr_ptr with wrap; the first eligible lane wins.
    always_comb begin
        int lane;
        // NOTE: every variable gets a default before any conditional update,
        // so this block can never infer a latch.
        lane         = 0;
        grant_vld    = 1'b0;
        grant_idx    = '0;
        grant_onehot = '0;
        grant_addr   = '0;
        grant_data   = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            lane = int'(rr_ptr) + i;
            if (lane >= NUM_REQ) begin
                lane = lane - NUM_REQ;
            end
            if (!grant_vld && eligible[lane]) begin
                grant_vld          = 1'b1;
                grant_idx          = PTR_W'(lane);
                grant_onehot[lane] = 1'b1;
                grant_addr         = hw_mem_wr_addr[lane*ADDR_WIDTH +: ADDR_WIDTH];
                grant_data         = hw_mem_wr_data[lane*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    // Pointer moves just past the winner; a layer start forces it back to lane 0.
    always_comb begin
        rr_ptr_next = rr_ptr;
        if (layer_start_p) begin
            rr_ptr_next = '0;
        end else if (grant_vld) begin
            rr_ptr_next = (grant_idx == LAST_LANE) ? '0 : grant_idx + PTR_W'(1);
        end
    end

    // Register the grant onto the memory port and the ack bus.
    always_ff @(posedge clk or negedge resetn) begin
        // NOTE: the write address/data registers are reset too, because the
        // memory port must read as all-zero while the block is held in reset.
        if (!resetn) begin
            rr_ptr          <= '0;
            act_mem_wr_en   <= 1'b0;
            act_mem_wr_addr <= '0;
            act_mem_wr_data <= '0;
            hw_mem_wr_ack_p <= '0;
        end else begin
            // NOTE: non-blocking assignments keep every register here sampling
            // the pre-edge values, independent of statement order.
            rr_ptr          <= rr_ptr_next;
            act_mem_wr_en   <= grant_vld;
            hw_mem_wr_ack_p <= grant_onehot;
            if (grant_vld) begin
                act_mem_wr_addr <= grant_addr;
                act_mem_wr_data <= grant_data;
            end
        end
    end

    // Count committed writes since the last layer start, saturating at max.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            wr_count_o <= '0;
        end else if (layer_start_p) begin
            wr_count_o <= '0;
        end else if (act_mem_wr_en && (wr_count_o != CNT_MAX)) begin
            wr_count_o <= wr_count_o + CNT_WIDTH'(1);
        end
    end

    // Busy while anything is waiting for a grant or a write is on the port.
    assign busy_o = resetn & ((|eligible) | act_mem_wr_en);

endmodule

// File: tb/tb_npu_act_wr_arbiter.sv
// Self-checking bench for npu_act_wr_arbiter: directed scenarios plus
// randomized lane traffic, all compared against a behavioural model.

module tb_npu_act_wr_arbiter;

    localparam int N       = 32;
    localparam int AW      = 12;
    localparam int DW      = 16;
    localparam int CW      = 13;
    localparam int CNT_MAX = 8191;

    logic          clk = 1'b0;
    logic          resetn;
    logic          layer_start;
    logic [N-1:0]  req;
    logic [N*AW-1:0] addr_v;
    logic [N*DW-1:0] data_v;
    logic [N-1:0]  ack;
    logic          wr_en;
    logic [AW-1:0] wr_addr;
    logic [DW-1:0] wr_data;
    logic [CW-1:0] wr_count;
    logic          busy;

    npu_act_wr_arbiter #(
        .NUM_REQ(N), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .CNT_WIDTH(CW)
    ) dut (
        .clk             (clk),
        .resetn          (resetn),
        .layer_start_p   (layer_start),
        .hw_mem_wr       (req),
        .hw_mem_wr_addr  (addr_v),
        .hw_mem_wr_data  (data_v),
        .hw_mem_wr_ack_p (ack),
        .act_mem_wr_en   (wr_en),
        .act_mem_wr_addr (wr_addr),
        .act_mem_wr_data (wr_data),
        .wr_count_o      (wr_count),
        .busy_o          (busy)
    );

    always #5 clk = ~clk;

    // Reference model state: what the port should show after the last edge.
    logic          m_en;
    logic [AW-1:0] m_addr;
    logic [DW-1:0] m_data;
    logic [N-1:0]  m_ack;
    int            m_ptr;
    int            m_cnt;
    logic [N-1:0]  last_ack;
    int            ack_seen [N];

    int n_total = 0;
    int n_pass  = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    endtask

    // Lane whose rotational distance from the pointer is smallest.
    function automatic int pick(input logic [N-1:0] elig, input int ptr);
        int best   = -1;
        int best_d = N;
        for (int l = 0; l < N; l++) begin
            if (elig[l]) begin
                int d;
                d = (l - ptr + N) % N;
                if (d < best_d) begin
                    best_d = d;
                    best   = l;
                end
            end
        end
        return best;
    endfunction

    task automatic model_reset();
        m_en = 1'b0; m_addr = '0; m_data = '0; m_ack = '0;
        m_ptr = 0; m_cnt = 0; last_ack = '0;
    endtask

    // One clock: called at posedge+1 with inputs already set.
    task automatic cycle();
        logic [N-1:0] elig;
        int w;
        last_ack = m_ack;
        for (int i = 0; i < N; i++) if (ack[i]) ack_seen[i]++;
        @(negedge clk);
        elig = req & ~m_ack;
        check("busy", 32'(busy), 32'((|elig) || m_en));
        if (layer_start) m_cnt = 0;
        else if (m_en && m_cnt < CNT_MAX) m_cnt++;
        w = pick(elig, m_ptr);
        if (w >= 0) begin
            m_en   = 1'b1;
            m_addr = addr_v[w*AW +: AW];
            m_data = data_v[w*DW +: DW];
            m_ack  = '0;
            m_ack[w] = 1'b1;
            m_ptr  = (w + 1) % N;
        end else begin
            m_en  = 1'b0;
            m_ack = '0;
        end
        if (layer_start) m_ptr = 0;
        @(posedge clk);
        #1;
        layer_start = 1'b0;
        check("wr_en",    32'(wr_en),    32'(m_en));
        check("ack",      32'(ack),      32'(m_ack));
        check("wr_addr",  32'(wr_addr),  32'(m_addr));
        check("wr_data",  32'(wr_data),  32'(m_data));
        check("wr_count", 32'(wr_count), 32'(m_cnt));
    endtask

    // Lanes that saw their ack during the cycle just finished drop out.
    task automatic release_acked();
        req = req & ~last_ack;
    endtask

    task automatic new_req(input int i);
        req[i] = 1'b1;
        addr_v[i*AW +: AW] = AW'($urandom);
        data_v[i*DW +: DW] = DW'($urandom);
    endtask

    // Contract-respecting random lane behaviour for the next cycle.
    task automatic lanes_random(input int prob);
        for (int i = 0; i < N; i++) begin
            if (last_ack[i]) begin
                if ($urandom_range(99) < prob) new_req(i);
                else req[i] = 1'b0;
            end else if (!req[i]) begin
                if ($urandom_range(99) < prob) new_req(i);
            end else if (!m_ack[i] && $urandom_range(99) == 0) begin
                req[i] = 1'b0;
            end
        end
    endtask

    task automatic quiesce();
        int k;
        for (k = 0; k < 300; k++) begin
            if (req == '0 && !m_en && m_ack == '0) break;
            lanes_random(0);
            cycle();
        end
        check("quiesce_timeout", 32'(k < 300), 32'd1);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int k;
        logic found;
        resetn = 1'b0; layer_start = 1'b0;
        req = 32'h0000_FFFF; addr_v = '0; data_v = '0;
        for (int i = 0; i < N; i++) ack_seen[i] = 0;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        check("rst_en",    32'(wr_en),    0);
        check("rst_ack",   32'(ack),      0);
        check("rst_addr",  32'(wr_addr),  0);
        check("rst_data",  32'(wr_data),  0);
        check("rst_count", 32'(wr_count), 0);
        check("rst_busy",  32'(busy),     0);
        req = '0;
        resetn = 1'b1;

        // Single write from lane 4.
        req[4] = 1'b1;
        addr_v[4*AW +: AW] = 12'h010;
        data_v[4*DW +: DW] = 16'h00AB;
        cycle();
        check("t1_en",   32'(wr_en),   1);
        check("t1_addr", 32'(wr_addr), 32'h010);
        check("t1_data", 32'(wr_data), 32'h00AB);
        check("t1_ack",  32'(ack),     32'h0000_0010);
        cycle();
        check("t1_idle_en", 32'(wr_en),    0);
        check("t1_count",   32'(wr_count), 1);
        release_acked();

        // Pointer at 5: lanes 3 and 7 -> 7 first, then 3, pointer ends at 4.
        new_req(3); new_req(7);
        cycle();
        check("rr_first",  32'(ack), 32'h0000_0080);
        release_acked();
        cycle();
        check("rr_second", 32'(ack), 32'h0000_0008);
        release_acked();
        cycle();
        release_acked();
        new_req(3); new_req(5);
        cycle();
        check("rr_ptr4", 32'(ack), 32'h0000_0020);
        release_acked();
        quiesce();

        // All lanes at once from pointer 0.
        layer_start = 1'b1;
        cycle();
        for (int i = 0; i < N; i++) ack_seen[i] = 0;
        for (int i = 0; i < N; i++) begin
            req[i] = 1'b1;
            addr_v[i*AW +: AW] = AW'(i);
            data_v[i*DW +: DW] = DW'($urandom);
        end
        for (int j = 0; j < N; j++) begin
            cycle();
            check("drain_addr", 32'(wr_addr), 32'(j));
            check("drain_ack",  32'(ack),     32'(1) << j);
            release_acked();
        end
        cycle();
        release_acked();
        check("drain_count", 32'(wr_count), 32);
        #1;
        check("drain_busy_low", 32'(busy), 0);
        for (int i = 0; i < N; i++) check("drain_once", 32'(ack_seen[i]), 1);

        // Lane 0 back-to-back: one write every other cycle.
        layer_start = 1'b1;
        cycle();
        for (int j = 0; j < 4; j++) begin
            req[0] = 1'b1;
            addr_v[0 +: AW] = AW'(12'h100 + j);
            data_v[0 +: DW] = DW'($urandom);
            cycle();
            check("b2b_write", 32'(wr_en),   1);
            check("b2b_addr",  32'(wr_addr), 32'h100 + 32'(j));
            cycle();
            check("b2b_gap",   32'(wr_en),   0);
        end
        req[0] = 1'b0;
        check("b2b_count", 32'(wr_count), 4);

        // Random traffic until 100 writes are counted with one in flight.
        found = 1'b0;
        for (k = 0; k < 2000; k++) begin
            if (m_cnt == 100 && m_en) begin
                found = 1'b1;
                break;
            end
            lanes_random(60);
            cycle();
        end
        check("reach_100", 32'(found), 1);
        lanes_random(60);
        layer_start = 1'b1;
        cycle();
        check("ls_clear", 32'(wr_count), 0);
        for (int j = 0; j < 200; j++) begin
            lanes_random(40);
            if ($urandom_range(49) == 0) layer_start = 1'b1;
            cycle();
        end

        // Sustained traffic drives the counter into saturation.
        layer_start = 1'b1;
        for (int j = 0; j < 8400; j++) begin
            lanes_random(100);
            cycle();
        end
        check("sat_count", 32'(wr_count), CNT_MAX);
        quiesce();

        // Reset in the middle of a 10-lane drain.
        for (int i = 0; i < N; i++) ack_seen[i] = 0;
        for (int i = 2; i < 12; i++) new_req(i);
        for (int j = 0; j < 3; j++) begin
            cycle();
            release_acked();
        end
        resetn = 1'b0;
        #1;
        check("mid_rst_en",    32'(wr_en),    0);
        check("mid_rst_ack",   32'(ack),      0);
        check("mid_rst_addr",  32'(wr_addr),  0);
        check("mid_rst_data",  32'(wr_data),  0);
        check("mid_rst_count", 32'(wr_count), 0);
        check("mid_rst_busy",  32'(busy),     0);
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        resetn = 1'b1;
        for (k = 0; k < 40; k++) begin
            if (req == '0 && !m_en && m_ack == '0) break;
            cycle();
            release_acked();
        end
        check("mid_rst_drain_timeout", 32'(k < 40), 1);
        for (int i = 0; i < N; i++)
            check("mid_rst_ack_once", 32'(ack_seen[i]), 32'((i >= 2 && i < 12) ? 1 : 0));

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/npu_act_wr_arbiter.md
Name: npu_act_wr_arbiter

Overview:
Round-robin arbiter that merges the per-MAC activation write requests from the NPU layer datapath onto the single write port of the activation memory. It grants at most one write per cycle and returns a one-cycle acknowledge pulse to the winning lane. It also keeps a per-layer write count for the control unit and for debug readback. It sits between the layer unit's hw_mem_wr/addr/data/ack_p bus and the activation memory port A inside the image/activation memory controller.

Parameters:
NUM_REQ, 32, number of requesting MAC lanes
ADDR_WIDTH, 12, activation memory address width
DATA_WIDTH, 16, activation word width (instantiated with NPU_ACT_DATA_WIDTH)
CNT_WIDTH, 13, width of the write counter

Ports:
clk  input  1  NPU clock
resetn  input  1  asynchronous active-low reset
layer_start_p  input  1  one-cycle pulse: clear RR pointer and write counter
hw_mem_wr  input  NUM_REQ  per-lane write request, level, held until acked
hw_mem_wr_addr  input  NUM_REQ*ADDR_WIDTH  per-lane address, lane i at [i*ADDR_WIDTH +: ADDR_WIDTH]
hw_mem_wr_data  input  NUM_REQ*DATA_WIDTH  per-lane data, lane i at [i*DATA_WIDTH +: DATA_WIDTH]
hw_mem_wr_ack_p  output  NUM_REQ  one-hot one-cycle ack to winning lane
act_mem_wr_en  output  1  activation memory write enable
act_mem_wr_addr  output  ADDR_WIDTH  activation memory write address
act_mem_wr_data  output  DATA_WIDTH  activation memory write data
wr_count_o  output  CNT_WIDTH  writes committed since last layer_start_p, saturating
busy_o  output  1  pending eligible request or write in flight

Behaviour:
- Reset (resetn=0, async): hw_mem_wr_ack_p=0, act_mem_wr_en=0, act_mem_wr_addr=0, act_mem_wr_data=0, wr_count_o=0, rr_ptr=0. busy_o=0 while in reset.
- Eligibility: eligible = hw_mem_wr & ~hw_mem_wr_ack_p.
  - A lane acked this cycle is masked, because it can still be asserting its request for one more cycle.
  - Consequence: a single lane issuing back-to-back writes gets at most one grant every 2 cycles.
- Arbitration (combinational on eligible; rr_ptr in 0..NUM_REQ-1):
  - Winner = first eligible lane scanning rr_ptr, rr_ptr+1, ... with wrap at NUM_REQ-1 -> 0.
  - No eligible lane means no grant.
- Registered outputs, 1-cycle latency. On the edge after a grant to lane w:
  - act_mem_wr_en=1.
  - act_mem_wr_addr and act_mem_wr_data take lane w's slices.
  - hw_mem_wr_ack_p = 1<<w.
  - rr_ptr = (w+1) mod NUM_REQ.
  - No grant: act_mem_wr_en=0 and ack=0. addr/data hold their previous values. rr_ptr unchanged.
- Requester contract:
  - Lane holds hw_mem_wr, addr and data stable from assertion until the cycle ack_p is seen.
  - Lane may deassert, or present a new request, on the cycle after ack.
  - A request dropped before ack is legal. If no grant was issued, no write occurs.
- Write counter: increments by 1 on every cycle act_mem_wr_en=1 and saturates at 2^CNT_WIDTH-1.
- layer_start_p (synchronous):
  - Sets rr_ptr=0 and wr_count_o=0 for the next cycle.
  - If act_mem_wr_en=1 in the same cycle, that write is not counted.
  - Arbitration in the same cycle still proceeds. The grant uses the pre-clear rr_ptr and does not move it; rr_ptr becomes 0.
- busy_o = (|eligible) | act_mem_wr_en, combinational.
- Simultaneous requests: exactly one grant per cycle. All NUM_REQ lanes asserting together drain in NUM_REQ consecutive cycles, in rotation order from rr_ptr.
- Never two acks in one cycle. Never a write without a matching ack.

Test Plan:
- Reset then lane 4 requests addr 0x010, data 0x00AB -> next cycle: act_mem_wr_en=1, addr=0x010, data=0x00AB, ack_p=0x00000010. Lane drops the request -> next cycle wr_en=0, wr_count_o=1.
- All 32 lanes request at once, lane i addr=i, rr_ptr=0 -> 32 consecutive writes with addr 0..31, each lane acked exactly once, wr_count_o=32, busy_o falls after the last write.
- rr_ptr=5 (after a grant to lane 4), lanes 3 and 7 request -> lane 7 granted first, lane 3 on the following cycle, rr_ptr ends at 4.
- Lane 0 re-requests every cycle after each ack, with new addr each time, for 4 writes -> writes land on alternate cycles (8 cycles total), no duplicate writes, wr_count_o=4.
- Counter and pulse interaction:
  - layer_start_p while wr_count_o=100 and a write is in flight -> wr_count_o=0 next cycle.
  - Subsequent arbitration starts from lane 0.
  - wr_count_o saturates at 8191 under sustained writes.
- resetn asserted mid-drain with 10 lanes pending -> all outputs 0 immediately. After release, pending lanes are re-arbitrated from lane 0 with no lost or duplicated acks.
